// File: rtl/serializer_pkg.sv
// Shared types and helpers for the PISO serializer.
// FSM state encoding and frame-length arithmetic.
package serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  function automatic int frame_len(
    input int w,
    input int framed,
    input int stop_bits
  );
    return (framed != 0) ? (w + 1 + stop_bits) : w;
  endfunction

endpackage

// File: rtl/piso_hold_reg.sv
// One-word valid/ready holding register.
// Emptied by the shift engine's load strobe.
module piso_hold_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  load,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] hold_data,
  output logic                  hold_full
);

  logic accept;

  assign ready  = ~hold_full;
  assign accept = valid & ~hold_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_full <= 1'b0;
    end else begin
      hold_full <= accept | (hold_full & ~load);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      hold_data <= data_in;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with optional
// start/stop framing and back-to-back frames.
module piso_serializer
  import serializer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MSB_FIRST  = 0,
  parameter int FRAMED     = 1,
  parameter int STOP_BITS  = 1,
  parameter int IDLE_LEVEL = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  shift,
  output logic                  ready,
  output logic                  srl_out,
  output logic                  tx_active,
  output logic                  frame_done
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic IDLE_BIT  = 1'(IDLE_LEVEL);
  localparam bit   FR        = (FRAMED != 0);
  localparam bit   MSBF      = (MSB_FIRST != 0);

  state_e                  state;
  logic [CW-1:0]           cnt;
  logic                    stop_cnt;
  logic [DATA_WIDTH-1:0]   shreg;
  logic [DATA_WIDTH-1:0]   hold_data;
  logic                    hold_full;
  logic                    load;
  logic                    frame_end;

  function automatic logic bit_at(
    input logic [DATA_WIDTH-1:0] d,
    input logic [CW-1:0]         i
  );
    if (MSBF) return d[LAST - i];
    return d[i];
  endfunction

  piso_hold_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_hold (
    .clk       (clk),
    .rst       (rst),
    .valid     (valid),
    .data_in   (data_in),
    .load      (load),
    .ready     (ready),
    .hold_data (hold_data),
    .hold_full (hold_full)
  );

  // Last bit period of a frame ends on this shift edge.
  assign frame_end = shift & (
    ((state == ST_DATA) && (cnt == LAST) && !FR) ||
    ((state == ST_STOP) && (stop_cnt == LAST_STOP)));

  assign load = shift & hold_full &
    ((state == ST_IDLE) | frame_end);

  assign tx_active = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      stop_cnt   <= 1'b0;
      srl_out    <= IDLE_BIT;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (load) begin
        cnt      <= '0;
        stop_cnt <= 1'b0;
        if (FR) begin
          state   <= ST_START;
          srl_out <= ~IDLE_BIT;
        end else begin
          state   <= ST_DATA;
          srl_out <= bit_at(hold_data, '0);
        end
      end else if (shift) begin
        unique case (state)
          ST_START: begin
            state   <= ST_DATA;
            cnt     <= '0;
            srl_out <= bit_at(shreg, '0);
          end
          ST_DATA: begin
            if (cnt == LAST) begin
              state    <= FR ? ST_STOP : ST_IDLE;
              stop_cnt <= 1'b0;
              srl_out  <= IDLE_BIT;
            end else begin
              cnt     <= cnt + 1'b1;
              srl_out <= bit_at(shreg, cnt + 1'b1);
            end
          end
          ST_STOP: begin
            if (stop_cnt == LAST_STOP) begin
              state <= ST_IDLE;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
          default: begin
            srl_out <= IDLE_BIT;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      shreg <= hold_data;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed self-checking bench for piso_serializer.
// Three parameterisations share one clock.
module tb_piso_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        rst0, rst2;
  logic        valid0, valid1, valid2;
  logic [7:0]  data0, data2;
  logic [11:0] data1;
  logic        shift0, shift1, shift2;
  logic        ready0, ready1, ready2;
  logic        srl0, srl1, srl2;
  logic        tx0, tx1, tx2;
  logic        fd0, fd1, fd2;

  piso_serializer u0 (
    .clk(clk), .rst(rst0), .valid(valid0), .data_in(data0),
    .shift(shift0), .ready(ready0), .srl_out(srl0),
    .tx_active(tx0), .frame_done(fd0)
  );

  piso_serializer #(
    .DATA_WIDTH(12), .MSB_FIRST(1), .FRAMED(0)
  ) u1 (
    .clk(clk), .rst(rst0), .valid(valid1), .data_in(data1),
    .shift(shift1), .ready(ready1), .srl_out(srl1),
    .tx_active(tx1), .frame_done(fd1)
  );

  piso_serializer #(
    .STOP_BITS(2)
  ) u2 (
    .clk(clk), .rst(rst2), .valid(valid2), .data_in(data2),
    .shift(shift2), .ready(ready2), .srl_out(srl2),
    .tx_active(tx2), .frame_done(fd2)
  );

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (srl0 !== 1'b1 || ready0 !== 1'b1 ||
        tx0 !== 1'b0 || fd0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_u0 got srl=%b rdy=%b tx=%b fd=%b exp 1 1 0 0",
               srl0, ready0, tx0, fd0);
    end
    checks++;
    if (srl1 !== 1'b1 || ready1 !== 1'b1 || tx1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_u1 got srl=%b rdy=%b tx=%b exp 1 1 0",
               srl1, ready1, tx1);
    end
    checks++;
    if (srl2 !== 1'b1 || ready2 !== 1'b1 || tx2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_u2 got srl=%b rdy=%b tx=%b exp 1 1 0",
               srl2, ready2, tx2);
    end
    @(negedge clk);
    rst0 = 1'b1;
    rst2 = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [0:9] exp;
    int ntx, nfd;
    exp = 10'b0101001011;
    ntx = 0;
    nfd = 0;
    @(negedge clk);
    valid0 = 1'b1;
    data0  = 8'hA5;
    @(posedge clk);
    #1;
    valid0 = 1'b0;
    checks++;
    if (ready0 !== 1'b0 || srl0 !== 1'b1) begin
      errors++;
      $display("FAIL basic_accept got rdy=%b srl=%b exp 0 1",
               ready0, srl0);
    end
    for (int i = 0; i < 13; i++) begin
      @(posedge clk);
      #1;
      ntx += int'(tx0);
      nfd += int'(fd0);
      checks++;
      if (i < 10 && srl0 !== exp[i]) begin
        errors++;
        $display("FAIL basic_bit[%0d] got %b exp %b", i, srl0, exp[i]);
      end else if (i >= 10 && srl0 !== 1'b1) begin
        errors++;
        $display("FAIL basic_idle[%0d] got %b exp 1", i, srl0);
      end
    end
    checks++;
    if (ntx != 10 || nfd != 1) begin
      errors++;
      $display("FAIL basic_counts got tx=%0d fd=%0d exp 10 1", ntx, nfd);
    end
  endtask

  task automatic test_msb();
    logic [0:11] exp;
    exp = 12'b100000001111;
    @(negedge clk);
    valid1 = 1'b1;
    data1  = 12'h80F;
    @(posedge clk);
    #1;
    valid1 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (srl1 !== exp[i] || tx1 !== 1'b1) begin
        errors++;
        $display("FAIL msb_bit[%0d] got %b tx=%b exp %b tx=1",
                 i, srl1, tx1, exp[i]);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (srl1 !== 1'b1 || tx1 !== 1'b0 || fd1 !== 1'b1) begin
      errors++;
      $display("FAIL msb_end got srl=%b tx=%b fd=%b exp 1 0 1",
               srl1, tx1, fd1);
    end
    @(posedge clk);
    #1;
    checks++;
    if (srl1 !== 1'b1 || fd1 !== 1'b0) begin
      errors++;
      $display("FAIL msb_idle got srl=%b fd=%b exp 1 0", srl1, fd1);
    end
  endtask

  task automatic test_back_to_back();
    logic [0:19] exp;
    int ntx, nfd;
    exp = 20'b01000000010111111111;
    ntx = 0;
    nfd = 0;
    @(negedge clk);
    valid0 = 1'b1;
    data0  = 8'h01;
    @(posedge clk);
    #1;
    data0 = 8'hFF;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) begin
        checks++;
        if (ready0 !== 1'b1) begin
          errors++;
          $display("FAIL b2b_load_ready got %b exp 1", ready0);
        end
      end
      if (k == 1) begin
        valid0 = 1'b0;
        checks++;
        if (ready0 !== 1'b0) begin
          errors++;
          $display("FAIL b2b_second_accept got %b exp 0", ready0);
        end
      end
      ntx += int'(tx0);
      nfd += int'(fd0);
      checks++;
      if (srl0 !== exp[k]) begin
        errors++;
        $display("FAIL b2b_bit[%0d] got %b exp %b", k, srl0, exp[k]);
      end
    end
    @(posedge clk);
    #1;
    nfd += int'(fd0);
    checks++;
    if (srl0 !== 1'b1 || tx0 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle got srl=%b tx=%b exp 1 0", srl0, tx0);
    end
    checks++;
    if (ntx != 20 || nfd != 2) begin
      errors++;
      $display("FAIL b2b_counts got tx=%0d fd=%0d exp 20 2", ntx, nfd);
    end
  endtask

  task automatic test_slow_shift();
    logic [0:9] exp;
    logic s_srl[48];
    logic s_rdy[48];
    logic s_tx[48];
    logic s_fd[48];
    int nfd;
    exp = 10'b0001111001;
    nfd = 0;
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      shift0 = (c % 4 == 3);
      valid0 = (c == 0);
      data0  = 8'h3C;
      @(posedge clk);
      #1;
      s_srl[c] = srl0;
      s_rdy[c] = ready0;
      s_tx[c]  = tx0;
      s_fd[c]  = fd0;
      nfd += int'(fd0);
    end
    @(negedge clk);
    shift0 = 1'b1;
    valid0 = 1'b0;
    checks++;
    if (s_rdy[0] !== 1'b0 || s_rdy[2] !== 1'b0 || s_rdy[3] !== 1'b1) begin
      errors++;
      $display("FAIL slow_ready got %b%b%b exp 001",
               s_rdy[0], s_rdy[2], s_rdy[3]);
    end
    checks++;
    if (s_tx[2] !== 1'b0 || s_srl[2] !== 1'b1 || s_tx[3] !== 1'b1) begin
      errors++;
      $display("FAIL slow_start got tx2=%b srl2=%b tx3=%b exp 0 1 1",
               s_tx[2], s_srl[2], s_tx[3]);
    end
    for (int c = 3; c < 43; c++) begin
      checks++;
      if (s_srl[c] !== exp[(c - 3) / 4]) begin
        errors++;
        $display("FAIL slow_bit[c%0d] got %b exp %b",
                 c, s_srl[c], exp[(c - 3) / 4]);
      end
    end
    checks++;
    if (s_fd[43] !== 1'b1 || nfd != 1 || s_tx[43] !== 1'b0 ||
        s_srl[43] !== 1'b1) begin
      errors++;
      $display("FAIL slow_end got fd=%b nfd=%0d tx=%b srl=%b exp 1 1 0 1",
               s_fd[43], nfd, s_tx[43], s_srl[43]);
    end
  endtask

  task automatic test_stop2_reset();
    logic [0:10] exp_a, exp_b;
    int ntx, nfd, bad;
    exp_a = 11'b00101101011;
    exp_b = 11'b01111000011;
    ntx = 0;
    nfd = 0;
    @(negedge clk);
    valid2 = 1'b1;
    data2  = 8'h5A;
    @(posedge clk);
    #1;
    valid2 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      ntx += int'(tx2);
      nfd += int'(fd2);
      if (i < 11) begin
        checks++;
        if (srl2 !== exp_a[i]) begin
          errors++;
          $display("FAIL stop2_bit[%0d] got %b exp %b", i, srl2, exp_a[i]);
        end
      end
    end
    checks++;
    if (ntx != 11 || nfd != 1 || tx2 !== 1'b0) begin
      errors++;
      $display("FAIL stop2_len got tx=%0d fd=%0d exp 11 1", ntx, nfd);
    end
    @(negedge clk);
    valid2 = 1'b1;
    data2  = 8'hA5;
    @(posedge clk);
    #1;
    data2 = 8'hFF;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    valid2 = 1'b0;
    checks++;
    if (ready2 !== 1'b0) begin
      errors++;
      $display("FAIL stop2_hold_full got rdy=%b exp 0", ready2);
    end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (srl2 !== 1'b0 || tx2 !== 1'b1) begin
      errors++;
      $display("FAIL stop2_bit3 got srl=%b tx=%b exp 0 1", srl2, tx2);
    end
    rst2 = 1'b0;
    #1;
    checks++;
    if (srl2 !== 1'b1 || ready2 !== 1'b1 ||
        tx2 !== 1'b0 || fd2 !== 1'b0) begin
      errors++;
      $display("FAIL midframe_reset got srl=%b rdy=%b tx=%b fd=%b exp 1 1 0 0",
               srl2, ready2, tx2, fd2);
    end
    @(negedge clk);
    rst2 = 1'b1;
    bad = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (srl2 !== 1'b1 || tx2 !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_discard got %0d busy cycles exp 0", bad);
    end
    @(negedge clk);
    valid2 = 1'b1;
    data2  = 8'h0F;
    @(posedge clk);
    #1;
    valid2 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (i < 11 && srl2 !== exp_b[i]) begin
        errors++;
        $display("FAIL clean_bit[%0d] got %b exp %b", i, srl2, exp_b[i]);
      end else if (i == 11 && (srl2 !== 1'b1 || tx2 !== 1'b0)) begin
        errors++;
        $display("FAIL clean_end got srl=%b tx=%b exp 1 0", srl2, tx2);
      end
    end
  endtask

  initial begin
    rst0   = 1'b0;
    rst2   = 1'b0;
    valid0 = 1'b0;
    valid1 = 1'b0;
    valid2 = 1'b0;
    data0  = '0;
    data1  = '0;
    data2  = '0;
    shift0 = 1'b1;
    shift1 = 1'b1;
    shift2 = 1'b1;
    test_reset();
    test_basic();
    test_msb();
    test_back_to_back();
    test_slow_shift();
    test_stop2_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, meaning: word width in bits, legal range 2..64.
REQ-002 Parameter MSB_FIRST, default 0, meaning: 0 shifts bit 0 out first, 1 shifts bit DATA_WIDTH-1 out first.
REQ-003 Parameter FRAMED, default 1, meaning: 1 wraps each word in a start bit and stop bit(s), 0 sends raw data bits.
REQ-004 Parameter STOP_BITS, default 1, meaning: stop-bit count when FRAMED=1, legal values 1 or 2.
REQ-005 Parameter IDLE_LEVEL, default 1, meaning: line level when idle and stop-bit level; the start bit is ~IDLE_LEVEL.
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset; assertion is immediate, deassertion is synchronised externally.
REQ-008 valid  input  1  data_in is offered this cycle.
REQ-009 data_in  input  DATA_WIDTH  parallel word to send.
REQ-010 shift  input  1  bit-period tick; the line advances only on edges where shift=1.
REQ-011 ready  output  1  holding register empty; a word is accepted on any edge with valid=1 and ready=1.
REQ-012 srl_out  output  1  registered serial output.
REQ-013 tx_active  output  1  a frame is on the line.
REQ-014 frame_done  output  1  one-cycle pulse at the end of each frame's last bit period.

Function
REQ-015 The block SHALL hold two storage stages: a one-word holding register (hold, hold_full) and a shift engine (shreg, bit counter, FSM).
REQ-016 ready SHALL equal ~hold_full; accepting a word copies data_in to hold and sets hold_full on the same edge; data_in is ignored when ready=0.
REQ-017 The FSM states SHALL be IDLE, START, DATA and STOP; START and STOP are skipped when FRAMED=0.
REQ-018 In IDLE with hold_full=1 on a shift edge, the engine SHALL load shreg from hold and clear hold_full. srl_out gets the start bit (FRAMED=1, go to START) or the first data bit (FRAMED=0, go to DATA).
REQ-019 In DATA, each shift edge SHALL drive the next data bit in MSB_FIRST order; the bit counter of width $clog2(DATA_WIDTH) counts 0..DATA_WIDTH-1 with no wrap beyond.
REQ-020 After the last data bit, FRAMED=1 SHALL drive IDLE_LEVEL for STOP_BITS bit periods in STOP.
REQ-021 On the shift edge ending a frame's final bit period, frame_done SHALL pulse. If hold_full=1, the next frame starts on that same edge with no idle gap (back-to-back). Otherwise srl_out becomes IDLE_LEVEL and the FSM goes to IDLE.
REQ-022 tx_active SHALL be 1 from the edge that drives a frame's first bit until the edge that returns to IDLE.
REQ-023 Accept and engine-load on the same edge SHALL both complete: hold is freed by the load and refilled by the accept.
REQ-024 A word accepted while the engine is busy SHALL wait in hold; its bits SHALL never appear before the current frame completes.
REQ-025 Between shift edges, srl_out, FSM state and counter SHALL hold their value; valid/ready acceptance is independent of shift.
REQ-026 Frame length SHALL be DATA_WIDTH+1+STOP_BITS shift periods when FRAMED=1, and DATA_WIDTH periods when FRAMED=0.

Reset
REQ-027 Asserting rst (low) at any time, including mid-frame, SHALL immediately force: FSM=IDLE, srl_out=IDLE_LEVEL, ready=1, tx_active=0, frame_done=0, hold_full=0, counter=0.
REQ-028 A word in hold or in flight at reset SHALL be discarded; no partial frame resumes after reset.
REQ-029 Data registers (hold, shreg) need not be reset, but no output SHALL depend on them while in IDLE.

Structure
REQ-030 A shared package serializer_pkg SHALL hold the FSM state enum (2-bit encoding) and the helper function for frame length.
REQ-031 One sub-module, piso_hold_reg (valid/ready one-word holding register), SHALL be instantiated; the shift engine and FSM stay in piso_serializer.

Verification
REQ-032 Defaults, shift tied 1, send 8'hA5 -> srl_out sequence 0,1,0,1,0,0,1,0,1,1; tx_active high 10 cycles; one frame_done pulse.
REQ-033 MSB_FIRST=1, FRAMED=0, DATA_WIDTH=12, send 12'h80F -> line 1,0,0,0,0,0,0,0,1,1,1,1; then idle at 1.
REQ-034 Defaults, valid held with 8'h01 then 8'hFF -> second start bit immediately follows first stop bit; 20 contiguous bit periods; two frame_done pulses.
REQ-035 Defaults, shift every 4th cycle -> each bit stable exactly 4 cycles; ready drops on accept and rises on the load edge.
REQ-036 STOP_BITS=2 -> 11-period frame; rst pulsed low at data bit 3 -> srl_out=1, ready=1, tx_active=0 at once; next word sends a clean full frame.
